// File: rtl/vote_winner_scan.sv
// vote_winner_scan: sequential plurality winner finder over NUM_CAND snapshotted vote counts.
// Ports: clock, reset (async, active-high), start (sampled in IDLE), vote_counts (packed,
// candidate i at [i*COUNT_W +: COUNT_W]); busy (in SCAN), done (one-cycle result pulse),
// winner (one-hot), winner_idx, winning_votes, tie; with WINNER_MARGIN_EN defined also
// runner_up_votes and margin.
module vote_winner_scan #(
    parameter int NUM_CAND = 4,
    parameter int COUNT_W  = 8,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CAND*COUNT_W-1:0]  vote_counts,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CAND-1:0]          winner,
    output logic [IDX_W-1:0]             winner_idx,
    output logic [COUNT_W-1:0]           winning_votes,
    output logic                         tie
`ifdef WINNER_MARGIN_EN
    ,
    output logic [COUNT_W-1:0]           runner_up_votes,
    output logic [COUNT_W-1:0]           margin
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t               state, next_state;
    logic [COUNT_W-1:0]   snap [NUM_CAND];
    logic [COUNT_W-1:0]   best, best_n, cand;
    logic [IDX_W-1:0]     best_idx, best_idx_n, scan_idx;
    logic                 tie_w, tie_n, accept, last, gt;
`ifdef WINNER_MARGIN_EN
    logic [COUNT_W-1:0]   second, second_n;
`endif

    assign accept = (state == IDLE) && start;
    assign last   = (state == SCAN) && (scan_idx == LAST_IDX);
    assign cand   = snap[scan_idx];
    assign gt     = cand > best;

    // Running best after folding in the current candidate; lowest index keeps ties.
    always_comb begin
        best_n     = gt ? cand : best;
        best_idx_n = gt ? scan_idx : best_idx;
        tie_n      = gt ? 1'b0 : (cand == best) ? 1'b1 : tie_w;
`ifdef WINNER_MARGIN_EN
        second_n   = gt ? best : (cand > second) ? cand : second;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = accept ? SCAN : last ? IDLE : state;
    end

    always_comb begin
        busy = (state == SCAN);
    end

    // Snapshot isolates the scan from counters that keep moving.
    always_ff @(posedge clock) begin
        if (accept)
            for (int i = 0; i < NUM_CAND; i++)
                snap[i] <= vote_counts[i*COUNT_W +: COUNT_W];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            best     <= '0;
            best_idx <= '0;
            tie_w    <= 1'b0;
            scan_idx <= '0;
`ifdef WINNER_MARGIN_EN
            second   <= '0;
`endif
        end else if (accept) begin
            best     <= vote_counts[COUNT_W-1:0];
            best_idx <= '0;
            tie_w    <= 1'b0;
            scan_idx <= IDX_W'(1);
`ifdef WINNER_MARGIN_EN
            second   <= '0;
`endif
        end else if (state == SCAN) begin
            best     <= best_n;
            best_idx <= best_idx_n;
            tie_w    <= tie_n;
            scan_idx <= scan_idx + IDX_W'(1);
`ifdef WINNER_MARGIN_EN
            second   <= second_n;
`endif
        end
    end

    // Results load only on the final scan edge, so they never expose partial values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done          <= 1'b0;
            winner        <= '0;
            winner_idx    <= '0;
            winning_votes <= '0;
            tie           <= 1'b0;
`ifdef WINNER_MARGIN_EN
            runner_up_votes <= '0;
            margin          <= '0;
`endif
        end else begin
            done <= last;
            if (last) begin
                winner        <= NUM_CAND'(1) << best_idx_n;
                winner_idx    <= best_idx_n;
                winning_votes <= best_n;
                tie           <= tie_n;
`ifdef WINNER_MARGIN_EN
                runner_up_votes <= second_n;
                margin          <= best_n - second_n;
`endif
            end
        end
    end

endmodule

// File: doc/vote_winner_scan.md
# vote_winner_scan

Parametrised successor to the four-candidate winner finder. Snapshots NUM_CAND vote counters of COUNT_W bits on a start request, scans them sequentially one candidate per cycle, and reports winner index, one-hot winner, winning count and tie flag with a done pulse. Sits between the per-candidate vote counters and the result display/latch logic of the EVM. Because the scan is sequential, candidate count scales without a wide comparator tree.

## Interface
- NUM_CAND, 4, number of candidates; legal range 2..16
- COUNT_W, 8, width of each vote count
- IDX_W, $clog2(NUM_CAND), width of the winner index (derived; do not override)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a new evaluation; sampled only in IDLE
- vote_counts  in  NUM_CAND*COUNT_W  packed counts; candidate i occupies bits [i*COUNT_W +: COUNT_W]
- busy  out  1  high while in SCAN
- done  out  1  one-cycle pulse when results update
- winner  out  NUM_CAND  one-hot winner; bit i = candidate i
- winner_idx  out  IDX_W  binary winner index
- winning_votes  out  COUNT_W  winner's count
- tie  out  1  another candidate equals the winning count
- runner_up_votes  out  COUNT_W  present only with WINNER_MARGIN_EN
- margin  out  COUNT_W  present only with WINNER_MARGIN_EN

## Operation
- States: IDLE, SCAN.
- IDLE: start=1 at an edge → snapshot all of vote_counts into an internal register; working best=count[0], best_idx=0, tie_w=0, scan_idx=1; go to SCAN; busy=1.
- SCAN, one candidate per edge, c=snap[scan_idx]:
  - c > best: best=c, best_idx=scan_idx, tie_w=0.
  - c == best: tie_w=1; best/best_idx unchanged (lowest index wins ties).
  - c < best: no change.
- On the edge processing scan_idx=NUM_CAND-1: outputs winner, winner_idx, winning_votes, tie (and margin outputs) register the final values, done=1 for one cycle, return to IDLE.
- Comparisons are unsigned, COUNT_W bits; inputs are not sampled after the snapshot, so counter changes mid-scan have no effect.
- start while busy is ignored; there is no queueing.
- Result outputs hold until the next done; they never show partial scan values.
- All counts equal (including all zero): winner_idx=0, winner=1, tie=1.

## Timing
- Reset (asynchronous assert, synchronous deassert handled outside the block): state=IDLE, busy=0, done=0, winner=0, winner_idx=0, winning_votes=0, tie=0, runner_up_votes=0, margin=0.
- Latency: start sampled at edge k → busy high from edge k to edge k+NUM_CAND-1; done high during the cycle after edge k+NUM_CAND-1 (NUM_CAND=4: 3 cycles).
- Throughput: start may be asserted during the done cycle (state is IDLE); it is accepted and a new scan begins, giving one result per NUM_CAND cycles.
- Reset mid-scan: scan aborted, no done pulse, all outputs return to reset values immediately.
- start held high continuously: back-to-back scans, each taking a fresh snapshot.

## Configuration
- WINNER_MARGIN_EN defined: a second-best register tracks the runner-up during the scan. It initialises to 0 at start. When c > best, second=best. Otherwise second=max(second,c). runner_up_votes=second and margin=winning_votes-runner_up_votes are registered together with the other results. A tie gives margin=0.
- Not defined: runner_up_votes and margin ports and the associated logic are absent; all other behaviour is identical.

## Test plan
- Reset with NUM_CAND=4, COUNT_W=8 → all outputs 0, busy=0, done=0; start pulse with counts {c0..c3}={5,9,3,7} → done 3 cycles later, winner=4'b0010, winner_idx=1, winning_votes=9, tie=0; with macro, runner_up=7, margin=2.
- Counts {6,9,9,2} → winner_idx=1, tie=1, margin=0; counts all 0 → winner_idx=0, winner=4'b0001, tie=1.
- Change vote_counts to {200,0,0,0} one cycle after start, where the snapshot was {1,2,3,4} → result winner_idx=3, winning_votes=4; second start pulse while busy → ignored, only one done.
- Assert reset during the second SCAN cycle → outputs cleared immediately, no done; next start completes normally.
- NUM_CAND=16, COUNT_W=12, max 4095 at index 15, start held high → done pulses every 16 cycles, winner_idx=15, winner=16'h8000, winning_votes=4095.
